// File: rtl/disp_pkg.sv
// Shared display-path types and elaboration helpers for the sprite overlay.
package disp_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned CHAN_W  = 12;
    localparam int unsigned PIX_W   = 24;

    typedef struct packed {
        logic [CHAN_W-1:0] red;
        logic [CHAN_W-1:0] green;
        logic [CHAN_W-1:0] blue;
    } rgb12_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic int unsigned disp_dim(input int unsigned n, input int unsigned scale_log2);
        return n << scale_log2;
    endfunction

    // RGB888 sits in the upper 8 bits of each 12-bit channel.
    function automatic rgb12_t expand(input logic [PIX_W-1:0] p);
        rgb12_t c;
        c.red   = {p[23:16], 4'h0};
        c.green = {p[15:8],  4'h0};
        c.blue  = {p[7:0],   4'h0};
        return c;
    endfunction

endpackage

// File: rtl/sprite_ram.sv
// Simple dual-port sprite store: one write port, registered read (read-before-write).
module sprite_ram #(
    parameter int unsigned DEPTH = 100,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Out-of-range writes are dropped so a short sprite never aliases.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sprite_overlay.sv
// Composites a RAM-held RGB888 sprite over the 12-bit video stream with
// integer upscaling, colour-key transparency and frame-aligned repositioning.
module sprite_overlay
    import disp_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned IMG_W      = 10,
    parameter int unsigned IMG_H      = 10,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter bit          KEY_EN     = 1'b1,
    parameter logic [23:0] KEY_COLOR  = 24'hFF00FF,
    localparam int unsigned NPIX      = npix(IMG_W, IMG_H),
    localparam int unsigned AW        = clog2(NPIX)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [10:0]   iX_Cont,
    input  logic [10:0]   iY_Cont,
    input  logic          iDVAL,
    input  logic [11:0]   iRed,
    input  logic [11:0]   iGreen,
    input  logic [11:0]   iBlue,
    input  logic          iEnable,
    input  logic          iWr_en,
    input  logic [AW-1:0] iWr_addr,
    input  logic [23:0]   iWr_data,
    input  logic [10:0]   iPos_X,
    input  logic [10:0]   iPos_Y,
    input  logic          iPos_load,
    output logic [11:0]   oRed,
    output logic [11:0]   oGreen,
    output logic [11:0]   oBlue,
    output logic          oDVAL
);

    localparam int unsigned DISP_W = disp_dim(IMG_W, SCALE_LOG2);
    localparam int unsigned DISP_H = disp_dim(IMG_H, SCALE_LOG2);
    localparam int unsigned POS_X0 = (H_ACTIVE - DISP_W) / 2;
    localparam int unsigned POS_Y0 = (V_ACTIVE - DISP_H) / 2;

    logic [10:0] pos_x, pos_y;
    logic [10:0] pend_x, pend_y;
    logic        pend_vld;

    logic signed [11:0] dx_c, dy_c;
    logic [10:0]        lx_c, ly_c;
    logic               hit_c, frame_start_c;
    logic [AW-1:0]      addr_c;

    logic          s1_hit, s1_dval;
    rgb12_t        s1_bg;
    logic [AW-1:0] s1_addr;
    logic          s2_hit, s2_dval;
    rgb12_t        s2_bg;
    logic [23:0]   rd_data;
    rgb12_t        out_c, out_q;

    assign frame_start_c = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);

    // Position double buffer: the frame-start pixel still uses the old position.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pos_x    <= 11'(POS_X0);
            pos_y    <= 11'(POS_Y0);
            pend_x   <= '0;
            pend_y   <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (iPos_load) begin
                pend_x   <= iPos_X;
                pend_y   <= iPos_Y;
                pend_vld <= 1'b1;
            end else if (frame_start_c && pend_vld) begin
                pend_vld <= 1'b0;
            end
            if (frame_start_c && pend_vld) begin
                pos_x <= pend_x;
                pos_y <= pend_y;
            end
        end
    end

    // Hit test and sprite address; negative offsets fall outside, so no wrap.
    always_comb begin
        dx_c   = $signed({1'b0, iX_Cont}) - $signed({1'b0, pos_x});
        dy_c   = $signed({1'b0, iY_Cont}) - $signed({1'b0, pos_y});
        hit_c  = iDVAL && iEnable
                 && !dx_c[11] && (dx_c[10:0] < 11'(DISP_W))
                 && !dy_c[11] && (dy_c[10:0] < 11'(DISP_H));
        lx_c   = dx_c[10:0] >> SCALE_LOG2;
        ly_c   = dy_c[10:0] >> SCALE_LOG2;
        addr_c = '0;
        if (hit_c) begin
            addr_c = AW'(32'(ly_c) * IMG_W + 32'(lx_c));
        end
    end

    sprite_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (24)
    ) u_ram (
        .clk     (iCLK),
        .wr_en   (iWr_en),
        .wr_addr (iWr_addr),
        .wr_data (iWr_data),
        .rd_addr (s1_addr),
        .rd_data (rd_data)
    );

    // Final select; blanking forces black so sync intervals stay clean.
    always_comb begin
        out_c = '0;
        if (s2_dval) begin
            out_c = s2_bg;
            if (s2_hit && !(KEY_EN && (rd_data == KEY_COLOR))) begin
                out_c = expand(rd_data);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_hit  <= 1'b0;
            s1_dval <= 1'b0;
            s1_bg   <= '0;
            s1_addr <= '0;
            s2_hit  <= 1'b0;
            s2_dval <= 1'b0;
            s2_bg   <= '0;
            out_q   <= '0;
            oDVAL   <= 1'b0;
        end else begin
            s1_hit  <= hit_c;
            s1_dval <= iDVAL;
            s1_bg   <= '{red: iRed, green: iGreen, blue: iBlue};
            s1_addr <= addr_c;
            s2_hit  <= s1_hit;
            s2_dval <= s1_dval;
            s2_bg   <= s1_bg;
            out_q   <= out_c;
            oDVAL   <= s2_dval;
        end
    end

    assign oRed   = out_q.red;
    assign oGreen = out_q.green;
    assign oBlue  = out_q.blue;

endmodule
